// File: rtl/adc_pkg.sv
// Shared codec constants and the capture FSM state encoding.
package adc_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned CNT_W_DEF      = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        SHIFT_L = 3'd2,
        WAIT_R  = 3'd3,
        SHIFT_R = 3'd4,
        WAIT_L  = 3'd5
    } adc_state_e;

endpackage

// File: rtl/adc_pair_buf.sv
// One-entry holding register for completed stereo pairs, with sticky overrun.
module adc_pair_buf
    import adc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                         bclk,
    input  logic                         reset,
    input  logic                         commit,
    input  logic signed [DATA_WIDTH-1:0] commit_left,
    input  logic signed [DATA_WIDTH-1:0] commit_right,
    input  logic                         sample_ready,
    input  logic                         err_clear,
    output logic signed [DATA_WIDTH-1:0] left_data,
    output logic signed [DATA_WIDTH-1:0] right_data,
    output logic                         sample_valid,
    output logic                         overrun
);

    // A commit wins over a same-edge transfer; a commit into a stalled entry is dropped.
    always_ff @(posedge bclk or negedge reset) begin
        if (!reset) begin
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (commit && (!sample_valid || sample_ready)) begin
                left_data    <= commit_left;
                right_data   <= commit_right;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (commit && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (err_clear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc.sv
// Codec ADC deserializer: frames adcdat by adclrc into signed stereo pairs.
module adc
    import adc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                         bclk,
    input  logic                         reset,
    input  logic                         record,
    input  logic                         adclrc,
    input  logic                         adcdat,
    input  logic                         sample_ready,
    input  logic                         err_clear,
    output logic signed [DATA_WIDTH-1:0] left_data,
    output logic signed [DATA_WIDTH-1:0] right_data,
    output logic                         sample_valid,
    output logic                         overrun,
    output logic                         frame_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    adc_state_e            state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] left_tmp;
    logic                  lrc_d;

    logic                  lrc_fall_c;
    logic                  lrc_rise_c;
    logic                  last_bit_c;
    logic [DATA_WIDTH-1:0] shift_word_c;
    logic                  commit_c;

    assign lrc_fall_c   = !adclrc && lrc_d;
    assign lrc_rise_c   = adclrc && !lrc_d;
    assign last_bit_c   = (cnt == LAST_CNT);
    assign shift_word_c = {shift_q[DATA_WIDTH-2:0], adcdat};
    // The pair is handed over on the same edge that samples right bit 0.
    assign commit_c     = record && (state == SHIFT_R) && last_bit_c;

    always_ff @(posedge bclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_q   <= '0;
            left_tmp  <= '0;
            lrc_d     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            lrc_d     <= adclrc;
            frame_err <= 1'b0;
            if (!record) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: begin
                        if (lrc_fall_c) begin
                            state <= SHIFT_L;
                            cnt   <= '0;
                        end
                    end
                    SHIFT_L, SHIFT_R: begin
                        if ((lrc_fall_c || lrc_rise_c) && !last_bit_c) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                            state     <= lrc_fall_c ? SHIFT_L : SYNC;
                        end else if (last_bit_c) begin
                            // An lrc change on the LSB edge is the start of the next slot.
                            shift_q <= shift_word_c;
                            cnt     <= '0;
                            if (state == SHIFT_L) begin
                                left_tmp <= shift_word_c;
                                state    <= lrc_rise_c ? SHIFT_R : WAIT_R;
                            end else begin
                                state    <= lrc_fall_c ? SHIFT_L : WAIT_L;
                            end
                        end else begin
                            shift_q <= shift_word_c;
                            cnt     <= cnt + CNT_W'(1);
                        end
                    end
                    WAIT_R: begin
                        if (lrc_rise_c) begin
                            state <= SHIFT_R;
                            cnt   <= '0;
                        end
                    end
                    WAIT_L: begin
                        if (lrc_fall_c) begin
                            state <= SHIFT_L;
                            cnt   <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    adc_pair_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pair_buf (
        .bclk         (bclk),
        .reset        (reset),
        .commit       (commit_c),
        .commit_left  (left_tmp),
        .commit_right (shift_word_c),
        .sample_ready (sample_ready),
        .err_clear    (err_clear),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .overrun      (overrun)
    );

endmodule

// File: tb/tb_adc.sv
// Scoreboard bench for adc: I2S-style frames in, expected pairs queued, monitor compares.
module tb_adc;

    localparam int unsigned DW = 16;

    logic          bclk = 1'b0;
    logic          reset = 1'b0;
    logic          record = 1'b0;
    logic          adclrc = 1'b1;
    logic          adcdat = 1'b0;
    logic          sample_ready = 1'b0;
    logic          err_clear = 1'b0;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          sample_valid;
    logic          overrun;
    logic          frame_err;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    pair_t exp_q[$];
    pair_t mon_e;
    int    tests = 0;
    int    fails = 0;
    int    ferr_cnt = 0;
    int    run = 0;
    int    max_run = 0;
    logic  m_overrun = 1'b0;
    logic  pending = 1'b0;

    adc dut (
        .bclk         (bclk),
        .reset        (reset),
        .record       (record),
        .adclrc       (adclrc),
        .adcdat       (adcdat),
        .sample_ready (sample_ready),
        .err_clear    (err_clear),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 bclk = ~bclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must consume the oldest expected pair.
    initial begin
        forever begin
            @(negedge bclk);
            #1;
            if (frame_err) ferr_cnt++;
            if (sample_valid && sample_ready) begin
                run++;
                if (run > max_run) max_run = run;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pair: got %h/%h, required no pair", left_data, right_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (left_data !== mon_e.l || right_data !== mon_e.r) begin
                        fails++;
                        $display("FAIL pair_data: got %h/%h, required %h/%h",
                                 left_data, right_data, mon_e.l, mon_e.r);
                    end
                end
            end else begin
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input logic lrc, input logic dat);
        @(negedge bclk);
        adclrc = lrc;
        adcdat = dat;
    endtask

    // Data lags lrc by one bclk: slot cycle 0 carries the previous slot's LSB.
    task automatic slot(input logic lrc, input logic [DW-1:0] w, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            if (k == 0) cyc(lrc, pending);
            else        cyc(lrc, w[DW-k]);
        end
        if (k1 == DW) pending = w[0];
    endtask

    task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        slot(1'b0, l, 0, DW);
        slot(1'b1, r, 0, DW);
    endtask

    task automatic idle(input int n, input logic lrc);
        repeat (n) cyc(lrc, 1'b0);
    endtask

    // Reference buffer: occupied while an expected pair is still unconsumed.
    task automatic model_commit(input logic [DW-1:0] l, input logic [DW-1:0] r);
        if (exp_q.size() == 0) exp_q.push_back({l, r});
        else                   m_overrun = 1'b1;
    endtask

    task automatic stop_rec();
        cyc(1'b0, 1'b0);
        record = 1'b0;
        idle(2, 1'b1);
    endtask

    logic [DW-1:0] l, r, pl, pr, j1, j2;

    initial begin
        repeat (3) @(negedge bclk);
        #1;
        check("rst_left", left_data, 0);
        check("rst_right", right_data, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        @(negedge bclk);
        reset = 1'b1;

        // Standard frame, latency of sample_valid
        sample_ready = 1'b1;
        record = 1'b1;
        idle(3, 1'b1);
        frame(16'h8001, 16'h7FFE);
        model_commit(16'h8001, 16'h7FFE);
        cyc(1'b0, pending);
        #1;
        check("valid_before_lsb", sample_valid, 0);
        @(posedge bclk);
        #1;
        check("valid_at_lsb", sample_valid, 1);
        stop_rec();

        // record raised mid right slot
        idle(2, 1'b1);
        j1 = DW'($urandom);
        j2 = DW'($urandom);
        slot(1'b0, j1, 0, DW);
        slot(1'b1, j2, 0, 8);
        record = 1'b1;
        slot(1'b1, j2, 8, DW);
        l = DW'($urandom);
        r = DW'($urandom);
        frame(l, r);
        model_commit(l, r);
        cyc(1'b0, pending);
        stop_rec();

        // Overrun with stalled consumer
        sample_ready = 1'b0;
        record = 1'b1;
        idle(3, 1'b1);
        frame(16'h1234, 16'h5678);
        model_commit(16'h1234, 16'h5678);
        frame(16'h0F0F, 16'hF0F0);
        model_commit(16'h0F0F, 16'hF0F0);
        cyc(1'b0, pending);
        @(posedge bclk);
        #1;
        check("ovr_valid", sample_valid, 1);
        check("ovr_left_kept", left_data, 16'h1234);
        check("ovr_right_kept", right_data, 16'h5678);
        check("ovr_flag", overrun, 32'(m_overrun));
        @(negedge bclk);
        record = 1'b0;
        err_clear = 1'b1;
        @(negedge bclk);
        err_clear = 1'b0;
        m_overrun = 1'b0;
        #1;
        check("ovr_cleared", overrun, 32'(m_overrun));
        sample_ready = 1'b1;
        idle(3, 1'b1);

        // Short left slot, then short right slot
        record = 1'b1;
        idle(3, 1'b1);
        slot(1'b0, DW'($urandom), 0, 10);
        slot(1'b1, DW'($urandom), 0, DW);
        slot(1'b0, DW'($urandom), 0, DW);
        slot(1'b1, DW'($urandom), 0, 10);
        l = DW'($urandom);
        r = DW'($urandom);
        frame(l, r);
        model_commit(l, r);
        cyc(1'b0, pending);
        stop_rec();
        check("short_slot_errs", ferr_cnt, 2);

        // Back-to-back frames, consumer always ready
        record = 1'b1;
        idle(3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            l = DW'($urandom);
            r = DW'($urandom);
            if (i > 0) model_commit(pl, pr);
            frame(l, r);
            pl = l;
            pr = r;
        end
        model_commit(pl, pr);
        cyc(1'b0, pending);
        stop_rec();
        check("b2b_no_overrun", overrun, 32'(m_overrun));

        // Async reset in the middle of a right slot
        sample_ready = 1'b0;
        record = 1'b1;
        idle(3, 1'b1);
        l = DW'($urandom) | 16'h0001;
        r = DW'($urandom) | 16'h0001;
        frame(l, r);
        model_commit(l, r);
        slot(1'b0, DW'($urandom), 0, DW);
        j2 = DW'($urandom);
        slot(1'b1, j2, 0, 8);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", sample_valid, 0);
        check("arst_left", left_data, 0);
        check("arst_right", right_data, 0);
        check("arst_overrun", overrun, 0);
        check("arst_frame_err", frame_err, 0);
        exp_q.delete();
        m_overrun = 1'b0;
        @(negedge bclk);
        reset = 1'b1;
        sample_ready = 1'b1;
        slot(1'b1, j2, 8, DW);
        l = DW'($urandom);
        r = DW'($urandom);
        frame(l, r);
        model_commit(l, r);
        cyc(1'b0, pending);
        stop_rec();

        check("queue_drained", exp_q.size(), 0);
        check("frame_err_total", ferr_cnt, 2);
        check("valid_one_cycle", max_run, 1);
        check("final_overrun", overrun, 32'(m_overrun));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
